// File: rtl/calc_keypad_enc.sv
// Calculator keypad encoder: scans a 4x4 active-low matrix, debounces
// presses and releases, queues accepted key codes in a 4-deep FIFO and
// hands them to the calculator as single-cycle command strobes.
module calc_keypad_enc #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  input  logic       calc_busy,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic [2:0] fifo_level,
  output logic       overflow
);

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_N    = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_WAIT_RELEASE
  } state_t;

  state_t     state_q;
  logic [1:0] col_q;
  logic [7:0] div_q;
  logic [3:0] code_q;
  logic [3:0] cnt_q;

  logic       sample;
  logic       any_low;
  logic [1:0] row_idx;
  logic [3:0] key_code;
  logic [3:0] cnt_inc;
  logic       push;

  logic [3:0] mem_q [4];
  logic [1:0] rd_q;
  logic [1:0] wr_q;
  logic [2:0] level_q;
  logic [2:0] level_d;
  logic       ovf_q;
  logic [3:0] last_q;
  logic       valid_prev_q;
  logic       full;
  logic       pop;
  logic       wr_en;

  // Row decode at the settling window; push fires on the sample that completes the press debounce.
  always_comb begin
    sample  = (div_q == DIV_LAST);
    any_low = (rows != 4'hF);
    if (!rows[0])      row_idx = 2'd0;
    else if (!rows[1]) row_idx = 2'd1;
    else if (!rows[2]) row_idx = 2'd2;
    else               row_idx = 2'd3;
    key_code = {row_idx, col_q};
    cnt_inc  = cnt_q + 4'd1;
    push     = 1'b0;
    if (sample) begin
      case (state_q)
        ST_SCAN:     push = any_low && (DEB_N == 4'd1);
        ST_DEBOUNCE: push = any_low && (key_code == code_q) && (cnt_inc == DEB_N);
        default:     push = 1'b0;
      endcase
    end
  end

  // Column drive follows the registered column index.
  always_comb begin
    cols = ~(4'b0001 << col_q);
  end

  // Scan / debounce / release FSM; column only advances when the FSM (re)enters scanning.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_SCAN;
      col_q   <= 2'd0;
      div_q   <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      div_q <= sample ? '0 : div_q + 8'd1;
      if (sample) begin
        case (state_q)
          ST_SCAN: begin
            if (any_low) begin
              code_q <= key_code;
              if (push) begin
                state_q <= ST_WAIT_RELEASE;
                cnt_q   <= '0;
              end else begin
                state_q <= ST_DEBOUNCE;
                cnt_q   <= 4'd1;
              end
            end else begin
              col_q <= col_q + 2'd1;
            end
          end
          ST_DEBOUNCE: begin
            if (any_low && (key_code == code_q)) begin
              if (push) begin
                state_q <= ST_WAIT_RELEASE;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= ST_SCAN;
              cnt_q   <= '0;
              col_q   <= col_q + 2'd1;
            end
          end
          ST_WAIT_RELEASE: begin
            if (!any_low) begin
              if (cnt_inc == DEB_N) begin
                state_q <= ST_SCAN;
                cnt_q   <= '0;
                col_q   <= col_q + 2'd1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cnt_q <= '0;
            end
          end
          default: begin
            state_q <= ST_SCAN;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // Issue logic: strobe from a non-empty FIFO when the calculator is free, never two cycles running.
  always_comb begin
    full       = (level_q == 3'd4);
    cmd_valid  = (level_q != 3'd0) && !calc_busy && !valid_prev_q;
    pop        = cmd_valid;
    cmd        = cmd_valid ? mem_q[rd_q] : last_q;
    wr_en      = push && (!full || pop);
    fifo_level = level_q;
    overflow   = ovf_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
  end

  // FIFO storage and pointers; a full FIFO still accepts a push when the head is popped in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      level_q      <= '0;
      ovf_q        <= 1'b0;
      last_q       <= '0;
      valid_prev_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= key_code;
        wr_q        <= wr_q + 2'd1;
      end
      if (pop) begin
        rd_q   <= rd_q + 2'd1;
        last_q <= mem_q[rd_q];
      end
      if (push && full && !pop) ovf_q <= 1'b1;
      level_q      <= level_d;
      valid_prev_q <= cmd_valid;
    end
  end

endmodule

// File: doc/calc_keypad_enc.md
CALC_KEYPAD_ENC -- requirements
Module: calc_keypad_enc

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each keypad column is driven before its rows are sampled (legal 2..255).
REQ-002 Parameter DEBOUNCE, default 3: consecutive identical samples needed to accept a press or a release (legal 1..15).
REQ-003 clock  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rows  input  4  keypad row lines, active-low, externally pulled up; treated as already synchronized.
REQ-006 cols  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 calc_busy  input  1  high = calculator cannot accept a command this cycle.
REQ-008 cmd  output  4  command code delivered to the calculator cmd port.
REQ-009 cmd_valid  output  1  one-cycle strobe: cmd is valid and consumed this cycle.
REQ-010 fifo_level  output  3  number of queued codes, 0..4.
REQ-011 overflow  output  1  sticky flag: an accepted key was dropped because the FIFO was full.

Function
REQ-012 The column index shall advance 0->1->2->3->0 every SCAN_DIV cycles while in SCAN; cols shall equal ~(4'b0001 << index).
REQ-013 rows shall be sampled only on the last cycle of each column dwell (the settling window).
REQ-014 Key code = row*4 + col; if more than one row is low, the lowest row index shall win.
REQ-015 FSM states: SCAN, DEBOUNCE, WAIT_RELEASE.
REQ-016 SCAN: a sample with any row low shall latch the code, set the stable count to 1, freeze the column, and go to DEBOUNCE; all rows high keeps SCAN.
REQ-017 DEBOUNCE: at each sample, same code increments the count; a different code or all rows high returns to SCAN with the count cleared and the column advanced.
REQ-018 When the count reaches DEBOUNCE, the code shall be pushed to the FIFO the same cycle and the FSM shall go to WAIT_RELEASE.
REQ-019 With DEBOUNCE=1, the push shall happen on the detecting sample itself.
REQ-020 WAIT_RELEASE: the column stays frozen; DEBOUNCE consecutive all-high samples return to SCAN with the column advanced; any low sample clears the release count; no further push while held (no auto-repeat).
REQ-021 FIFO: 4 entries, first-in first-out, level 0..4.
REQ-022 A push when the FIFO is full shall drop the code, leave the contents unchanged and set overflow.
REQ-023 Push and pop in the same cycle shall both occur; level is unchanged, including when full.
REQ-024 Issue rule: cmd_valid rises when the FIFO is non-empty, calc_busy=0 and cmd_valid was 0 the previous cycle. This guarantees at least one idle cycle between strobes.
REQ-025 On an issue, cmd shall equal the FIFO head, and the head shall be popped that cycle.
REQ-026 cmd shall hold the last issued code between strobes.
REQ-027 Latency: a code pushed into an empty FIFO shall be issued on the next cycle if calc_busy=0.
REQ-028 calc_busy high shall stall issue indefinitely with no loss; queued codes keep their order.

Reset
REQ-029 While reset is high at a clock edge, the block shall enter SCAN with column 0 and clear all counters, the FIFO and overflow.
REQ-030 Output values after that edge: cols=4'b1110, cmd=4'd0, cmd_valid=0, fifo_level=0, overflow=0.
REQ-031 Reset asserted mid-debounce or mid-hold shall discard the pending key, and no push shall occur.
REQ-032 A key still held when reset deasserts shall be detected afresh and accepted once after full debounce.

Verification
REQ-033 Defaults, calc_busy=0; hold row 1 low while col 2 is driven -> exactly one strobe with cmd=4'd6, issued 9 cycles after the detecting sample (8 to push, 1 to issue); none while held.
REQ-034 Row 0 low for only 2 samples, then released -> no push, fifo_level stays 0, scanning resumes at the next column.
REQ-035 calc_busy=1; press/release keys 1,2,3,4,5 -> fifo_level reaches 4, overflow=1 after key 5; calc_busy=0 -> cmd 1,2,3,4 issued, each strobe 1 cycle, one idle cycle between.
REQ-036 Rows 0 and 2 low at once on col 3 -> cmd=4'd3 accepted.
REQ-037 Assert reset on the 2nd debounce sample -> no strobe, and outputs equal the REQ-030 values on the next cycle.
REQ-038 With the FIFO full, a push coinciding with a pop -> level stays 4, the new code is queued, overflow unchanged.
